// File: rtl/timer_dev_if.sv
// timer_dev_if: data-memory bus slice seen by the countdown timer.
//   addr  word select (0=CTRL, 1=PRESET, 2=COUNT, 3=reserved)
//   we    write strobe, already qualified by the core's address decode
//   din   write data
//   dout  read data of the addressed register (combinational)
//   irq   level interrupt request
// The master modport is the CPU side; the slave modport is the timer.
interface timer_dev_if;
    logic [1:0]  addr;
    logic        we;
    logic [31:0] din;
    logic [31:0] dout;
    logic        irq;

    modport master (output addr, we, din, input dout, irq);
    modport slave  (input addr, we, din, output dout, irq);
endinterface

// File: rtl/timer_dev.sv
// timer_dev: memory-mapped programmable countdown timer.
//   clk  system clock, rising edge
//   rst  asynchronous, active-high reset
//   bus  timer_dev_if slave port (addr/we/din in, dout/irq out)
// Registers: CTRL (EN bit0, MODE bits[2:1], IM bit3), PRESET, COUNT (read-only).
// COUNT is loaded from PRESET when the counter (re)starts and decrements to 0;
// expiry sets pending. One-shot mode then clears EN; auto-reload mode restarts
// and drops pending after one cycle. irq = IM & pending.
module timer_dev #(
    parameter int unsigned CNT_W = 32
) (
    input  logic        clk,
    input  logic        rst,
    timer_dev_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CNT  = 2'd2,
        INT  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    state_t           state;
    logic [3:0]       ctrl;
    logic [CNT_W-1:0] preset;
    logic [CNT_W-1:0] count;
    logic             pending;

    logic en;
    logic reload;
    logic im;
    logic ctrl_wr;
    logic preset_wr;
    logic expire;

    assign en        = ctrl[0];
    assign reload    = (ctrl[2:1] == 2'b01);   // MODE 1x behaves as one-shot
    assign im        = ctrl[3];
    assign ctrl_wr   = bus.we && (bus.addr == 2'd0);
    assign preset_wr = bus.we && (bus.addr == 2'd1);
    assign expire    = (state == CNT) && en && (count == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            ctrl    <= '0;
            preset  <= '0;
            count   <= '0;
            pending <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (en) state <= LOAD;
                end
                LOAD: begin
                    count <= preset;
                    state <= CNT;
                end
                CNT: begin
                    if (!en) begin
                        state <= IDLE;
                    end else if (count != '0) begin
                        count <= count - ONE;
                    end else begin
                        state <= INT;
                    end
                end
                INT: begin
                    if (reload) begin
                        state <= LOAD;
                    end else begin
                        ctrl[0] <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            // Placed after the FSM so a CPU CTRL write overrides the one-shot EN clear.
            if (ctrl_wr)   ctrl   <= bus.din[3:0];
            if (preset_wr) preset <= bus.din[CNT_W-1:0];

            // Expiry beats a simultaneous CTRL-write clear.
            if (expire)
                pending <= 1'b1;
            else if (ctrl_wr || ((state == INT) && reload))
                pending <= 1'b0;
        end
    end

    always_comb begin
        bus.dout = '0;
        case (bus.addr)
            2'd0:    bus.dout = {28'd0, ctrl};
            2'd1:    bus.dout = 32'(preset);
            2'd2:    bus.dout = 32'(count);
            default: bus.dout = '0;
        endcase
    end

    assign bus.irq = im & pending;

endmodule
